// File: rtl/set_assoc_cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    RESPOND
  } state_t;

  // Tags are stored zero-extended to the widest possible tag (word address bits).
  localparam int unsigned TAG_MAX = 30;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } meta_t;

  function automatic int unsigned off_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned words);
    return TAG_MAX - off_bits(words) - idx_bits(sets);
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Processor and memory bus bundle for the set-associative cache.
interface set_assoc_cache_if;
  logic        p_strobe;
  logic        p_rw;
  logic [31:0] p_address;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_ready;
  logic        m_strobe;
  logic        m_rw;
  logic [31:0] m_address;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  // master drives requests and memory responses; slave is the cache itself
  modport master (
    output p_strobe, p_rw, p_address, p_wdata, m_rdata, m_ready,
    input  p_rdata, p_ready, m_strobe, m_rw, m_address, m_wdata
  );

  modport slave (
    input  p_strobe, p_rw, p_address, p_wdata, m_rdata, m_ready,
    output p_rdata, p_ready, m_strobe, m_rw, m_address, m_wdata
  );
endinterface

// File: rtl/set_assoc_cache_plru.sv
// Per-set tree-PLRU state; bits point toward the less recently used half.
module cache_plru #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned WAY_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAY_W-1:0] access_way,
  input  logic             update,
  output logic [WAY_W-1:0] victim
);

  if (WAYS == 1) begin : g_direct
    logic unused_dm;
    assign unused_dm = ^{clk, reset, set_idx, access_way, update};
    assign victim    = '0;
  end else if (WAYS == 2) begin : g_two
    logic [SETS-1:0] bits;

    always_ff @(posedge clk) begin
      if (!reset) begin
        bits <= '0;
      end else if (update) begin
        bits[set_idx] <= ~access_way[0];
      end
    end

    assign victim = bits[set_idx];
  end else begin : g_four
    logic [2:0] bits [SETS];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int unsigned s = 0; s < SETS; s++) bits[s] <= '0;
      end else if (update) begin
        bits[set_idx][0] <= ~access_way[1];
        if (!access_way[1]) bits[set_idx][1] <= ~access_way[0];
        else                bits[set_idx][2] <= ~access_way[0];
      end
    end

    assign victim = bits[set_idx][0] ? {1'b1, bits[set_idx][2]} : {1'b0, bits[set_idx][1]};
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with tree-PLRU replacement.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PStrobe,
  input  logic        PRW,
  input  logic [31:0] PAddress,
  input  logic [31:0] PDataIn,
  output logic [31:0] PDataOut,
  output logic        PReady,
  output logic        MStrobe,
  output logic        MRW,
  output logic [31:0] MAddress,
  output logic [31:0] MDataOut,
  input  logic [31:0] MDataIn,
  input  logic        MReady
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int unsigned OFF_W  = off_bits(WORDS);
  localparam int unsigned IDX_W  = idx_bits(SETS);
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BEAT_W = (WORDS > 1) ? OFF_W : 1;

  state_t state, state_nx;

  logic [29:0]        wa_q;
  logic               rw_q;
  logic [31:0]        wdata_q;
  logic [WAY_W-1:0]   way_q;
  logic [BEAT_W-1:0]  beat;

  meta_t       meta [WAYS][SETS];
  logic [31:0] data [WAYS][SETS][WORDS];

  logic [IDX_W-1:0]   idx;
  logic [BEAT_W-1:0]  off;
  logic [TAG_MAX-1:0] tag_cur;
  logic               last_beat;
  logic               hit, inv_found;
  logic [WAY_W-1:0]   hit_way, inv_way, plru_way, victim;
  logic [29:0]        wb_wa, fill_wa;

  logic unused_addr;
  assign unused_addr = ^PAddress[1:0];

  assign idx       = IDX_W'(wa_q >> OFF_W);
  assign off       = BEAT_W'(wa_q) & BEAT_W'(WORDS - 1);
  assign tag_cur   = TAG_MAX'(wa_q >> (OFF_W + IDX_W));
  assign last_beat = (beat == BEAT_W'(WORDS - 1));
  assign wb_wa     = (meta[way_q][idx].tag << (OFF_W + IDX_W)) | (30'(idx) << OFF_W) | 30'(beat);
  assign fill_wa   = (wa_q & ~30'(WORDS - 1)) | 30'(beat);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (meta[w][idx].valid && meta[w][idx].tag == tag_cur && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!meta[w][idx].valid && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : plru_way;
  end

  cache_plru #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_plru (
    .clk        (clk),
    .reset      (reset),
    .set_idx    (idx),
    .access_way (way_q),
    .update     (state == RESPOND),
    .victim     (plru_way)
  );

  // Memory-side outputs depend only on state/beat, so they hold until MReady.
  always_comb begin
    state_nx = state;
    MStrobe  = 1'b0;
    MRW      = 1'b0;
    MAddress = '0;
    MDataOut = '0;
    case (state)
      IDLE:    if (PStrobe) state_nx = COMPARE;
      COMPARE: begin
        if (hit)                                                   state_nx = RESPOND;
        else if (meta[victim][idx].valid && meta[victim][idx].dirty) state_nx = WRITEBACK;
        else                                                       state_nx = FILL;
      end
      WRITEBACK: begin
        MStrobe  = 1'b1;
        MRW      = 1'b1;
        MAddress = {wb_wa, 2'b00};
        MDataOut = data[way_q][idx][beat];
        if (MReady && last_beat) state_nx = FILL;
      end
      FILL: begin
        MStrobe  = 1'b1;
        MAddress = {fill_wa, 2'b00};
        if (MReady && last_beat) state_nx = RESPOND;
      end
      RESPOND: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      beat     <= '0;
      PReady   <= 1'b0;
      PDataOut <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          meta[w][s].valid <= 1'b0;
          meta[w][s].dirty <= 1'b0;
        end
      end
    end else begin
      state    <= state_nx;
      PReady   <= 1'b0;
      PDataOut <= '0;
      case (state)
        IDLE: if (PStrobe) begin
          wa_q    <= PAddress[31:2];
          rw_q    <= PRW;
          wdata_q <= PDataIn;
        end
        COMPARE: way_q <= hit ? hit_way : victim;
        WRITEBACK: if (MReady) beat <= last_beat ? '0 : beat + 1'b1;
        FILL: if (MReady) begin
          data[way_q][idx][beat] <= MDataIn;
          beat <= last_beat ? '0 : beat + 1'b1;
          if (last_beat) meta[way_q][idx] <= '{valid: 1'b1, dirty: 1'b0, tag: tag_cur};
        end
        RESPOND: begin
          PReady <= 1'b1;
          if (rw_q) begin
            data[way_q][idx][off]  <= wdata_q;
            meta[way_q][idx].dirty <= 1'b1;
          end else begin
            PDataOut <= data[way_q][idx][off];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else if (state == COMPARE) begin
      if (hit && HitCount != '1)        HitCount  <= HitCount + 1'b1;
      else if (!hit && MissCount != '1) MissCount <= MissCount + 1'b1;
    end
  end
`endif

endmodule
